timer_share_ctrl: RTL and testbench
===================================

// Module: timer_share_ctrl
// PURPOSE
//  Shares one 6-bit up-counter interval timer, the same mod-64 counter as count_64, among NREQ requesters.
//  A round-robin arbiter picks one requester. A small FSM clears and runs the counter for that requester's
//  programmed length, then pulses a per-requester done. Sits between client FSMs and the shared timer.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  CW    6  counter width; interval lengths are 1..2**CW cycles
// PORTS
//  clock  in   1        system clock; all state updates on posedge
//  reset  in   1        synchronous, active-high reset
//  req    in   NREQ     req[i]=1 requests an interval; must stay high while granted
//  len    in   NREQ*CW  len[i*CW +: CW] = interval length for requester i; 0 means 2**CW
//  grant  out  NREQ     one-hot; high for exactly L cycles while requester owns the timer
//  done   out  NREQ     one-cycle pulse on done[w] when w's interval completes
//  busy   out  1        high in RUN and DONE states
//  count  out  CW       current timer value; 0 when not running
// BEHAVIOUR
//  Reset:
//  - grant, done, busy and count are all 0; state is IDLE; RR pointer is 0, so req[0] has top priority.
//  - Reset mid-interval aborts silently: no done pulse.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//  - Stays in IDLE if req==0.
//  - Otherwise picks winner w = first set req bit scanning ptr, ptr+1, ... with modulo-NREQ wrap.
//  - Latches last = len_w - 1 (mod 2**CW, so len 0 gives last = 2**CW-1) and sets ptr <= (w+1) mod NREQ.
//  - Next cycle: state RUN, grant = onehot(w), count = 0.
//  - Latency from req sampled high in IDLE to grant: 1 cycle.
//  RUN:
//  - count increments by 1 each cycle.
//  - If count == last, next state is DONE.
//  - Else if req[w]==0, this is an abort: next state is IDLE, grant and count go to 0, no done pulse.
//  - Completion takes priority: if count == last and req[w] drops in the same cycle, it still goes to DONE.
//  - len and other req bits are ignored while in RUN; len is sampled only at the IDLE decision.
//  DONE (exactly 1 cycle):
//  - grant = 0, done[w] = 1, count = 0, busy = 1. Next state is IDLE.
//  - No arbitration happens in DONE, so back-to-back intervals are spaced L+2 cycles apart.
//  Invariants:
//  - grant is at most one-hot; done is at most one-hot.
//  - done[i] never coincides with grant[j] for any i, j.
//  - count never exceeds last; with last = 2**CW-1 it reaches 63 and never overflows within an interval.
//  - busy == (state != IDLE).
//  Timer implementation:
//  - Internal CW-bit up-counter with synchronous clear.
//  - Cleared on reset, on the IDLE->RUN transition, on abort and in DONE.
// TESTING
//  1 Assert reset 2 cycles with req=4'hF -> grant=0, done=0, busy=0, count=0; first grant after release goes to req[0].
//  2 req=4'b0001, len0=3 sampled at cycle t -> grant[0] high t+1..t+3 with count 0,1,2; done[0] at t+4; busy low at t+5.
//  3 req=4'b0100, len2=0 -> grant[2] high 64 cycles with count 0..63, then a single done[2]; count back to 0.
//  4 req=4'hF held, all len=1 -> grant order 0,1,2,3,0, each grant 1 cycle, period 3 cycles; done follows each grant.
//  5 req1 alone, len1=10; drop req1 when count=2 -> grant=0 and count=0 next cycle, no done[1]; pending req3 wins on the following cycle.
//  6 req0 running, len=20; assert reset at count=5 -> next cycle all outputs 0, no done; after release req[0] wins again (ptr reset to 0).

Source files
------------

// File: rtl/timer_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_share_ctrl_if
// Bundles the request/grant signals between the client FSMs and the shared
// interval timer controller.
//   req   : per-requester request lines (client -> controller)
//   len   : packed per-requester interval lengths, CW bits each, 0 = 2**CW
//   grant : one-hot ownership of the timer (controller -> client)
//   done  : one-cycle completion pulse for the owner
//   busy  : controller is in RUN or DONE
//   count : current timer value, 0 when not running
// The master modport is the client side; the slave modport is the controller.
// ---------------------------------------------------------------------------
interface timer_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int CW   = 6
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      count;

    modport master (
        output req,
        output len,
        input  grant,
        input  done,
        input  busy,
        input  count
    );

    modport slave (
        input  req,
        input  len,
        output grant,
        output done,
        output busy,
        output count
    );
endinterface

// File: rtl/timer_share_ctrl.sv
// ---------------------------------------------------------------------------
// timer_share_ctrl
// Shares one CW-bit up-counting interval timer among NREQ requesters.
// A round-robin arbiter picks a winner in IDLE, the timer then runs for the
// winner's programmed length while its grant is high, and a single done pulse
// marks completion. Dropping the request while granted aborts the interval
// without a done pulse.
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of timer_share_ctrl_if (req, len in; grant, done,
//           busy, count out, all outputs registered)
// ---------------------------------------------------------------------------
module timer_share_ctrl #(
    parameter int NREQ = 4,
    parameter int CW   = 6
) (
    input  logic                clock,
    input  logic                reset,
    timer_share_ctrl_if.slave   bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   last;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   nextptr;
    logic [CW-1:0]   winlen;

    // Round-robin pick: scan requesters starting at ptr and wrapping around,
    // the first one found with its request high wins. The winner's length and
    // the pointer value that follows it are prepared here for the IDLE decision.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        nextptr = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        winlen  = bus.len[int'(win)*CW +: CW];
    end

    // Controller FSM with the timer folded in. All outputs are registered.
    // The last count value is latched as len-1 so that a length of 0 wraps to
    // all-ones and the counter reaches its maximum without overflowing.
    // Completion is tested before the abort condition so that a request
    // dropping on the final cycle still produces its done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            last      <= '0;
            bus.count <= '0;
            bus.grant <= '0;
            bus.done  <= '0;
            bus.busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done  <= '0;
                    bus.count <= '0;
                    if (found) begin
                        owner     <= win;
                        last      <= winlen - 1'b1;
                        ptr       <= nextptr;
                        bus.grant <= NREQ'(1) << win;
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end else begin
                        bus.grant <= '0;
                        bus.busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.count == last) begin
                        bus.grant <= '0;
                        bus.done  <= NREQ'(1) << owner;
                        bus.count <= '0;
                        state     <= DONE;
                    end else if (!bus.req[owner]) begin
                        bus.grant <= '0;
                        bus.count <= '0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bus.count <= bus.count + 1'b1;
                    end
                end
                DONE: begin
                    bus.done  <= '0;
                    bus.grant <= '0;
                    bus.count <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.done  <= '0;
                    bus.grant <= '0;
                    bus.count <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_share_ctrl
// Self-checking bench for timer_share_ctrl. Each stimulus cycle pushes the
// outputs expected after the next rising edge onto a scoreboard queue; a
// monitor on the falling edge pops entries that are due and compares them.
// ---------------------------------------------------------------------------
module tb_timer_share_ctrl;

    localparam int NREQ = 4;
    localparam int CW   = 6;

    typedef struct {
        int          tgt;
        string       tag;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [5:0]  c;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    string testName;
    exp_t  sbq[$];

    timer_share_ctrl_if #(.NREQ(NREQ), .CW(CW)) tif ();

    timer_share_ctrl #(.NREQ(NREQ), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif.slave)
    );

    // Free-running clock and cycle counter used to time-stamp expectations.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and records what the
    // outputs must look like once the following rising edge has sampled them.
    task automatic applyStimulus(input logic [3:0] rq, input logic [23:0] ln,
                                 input logic rs, input logic [3:0] eg,
                                 input logic [3:0] ed, input logic eb,
                                 input logic [5:0] ec);
        exp_t e;
        @(posedge clock);
        #1;
        tif.req = rq;
        tif.len = ln;
        reset   = rs;
        e.tgt = cyc + 1;
        e.tag = $sformatf("%s@%0d", testName, cyc + 1);
        e.g = eg;
        e.d = ed;
        e.b = eb;
        e.c = ec;
        sbq.push_back(e);
    endtask

    function automatic logic [23:0] mkLen(input logic [5:0] l0, input logic [5:0] l1,
                                          input logic [5:0] l2, input logic [5:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Scoreboard monitor: compares every due expectation on the falling edge.
    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.tgt < cyc)
                checkOutput({e.tag, "_late"}, 32'(cyc), 32'(e.tgt));
            checkOutput({e.tag, "_grant"}, 32'(tif.grant), 32'(e.g));
            checkOutput({e.tag, "_done"},  32'(tif.done),  32'(e.d));
            checkOutput({e.tag, "_busy"},  32'(tif.busy),  32'(e.b));
            checkOutput({e.tag, "_count"}, 32'(tif.count), 32'(e.c));
        end
    end

    initial begin
        logic [23:0] l;
        logic [3:0]  oh;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        tif.req = '0;
        tif.len = '0;

        // Reset held two cycles with every request high, then round robin
        // with all lengths 1: order 0,1,2,3,0 with a 3-cycle period.
        testName = "rst";
        l = mkLen(6'd1, 6'd1, 6'd1, 6'd1);
        applyStimulus(4'hF, l, 1'b1, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'hF, l, 1'b1, 4'h0, 4'h0, 1'b0, 6'd0);
        testName = "rr";
        for (int r = 0; r < 5; r++) begin
            oh = 4'b0001 << (r % 4);
            applyStimulus(4'hF, l, 1'b0, oh,   4'h0, 1'b1, 6'd0);
            applyStimulus(4'hF, l, 1'b0, 4'h0, oh,   1'b1, 6'd0);
            applyStimulus((r < 4) ? 4'hF : 4'h0, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);
        end
        applyStimulus(4'h0, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);

        // Length 3 on requester 0; request drops on the final cycle, which
        // must still complete with a done pulse.
        testName = "len3";
        l = mkLen(6'd3, 6'd9, 6'd9, 6'd9);
        applyStimulus(4'b0001, l, 1'b0, 4'b0001, 4'h0, 1'b1, 6'd0);
        applyStimulus(4'b0001, l, 1'b0, 4'b0001, 4'h0, 1'b1, 6'd1);
        applyStimulus(4'b0001, l, 1'b0, 4'b0001, 4'h0, 1'b1, 6'd2);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'b0001, 1'b1, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);

        // Length 0 means the full 64-cycle interval, count reaching 63.
        testName = "len64";
        l = mkLen(6'd5, 6'd5, 6'd0, 6'd5);
        for (int k = 0; k < 64; k++)
            applyStimulus(4'b0100, l, 1'b0, 4'b0100, 4'h0, 1'b1, 6'(k));
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'b0100, 1'b1, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);

        // Abort: requester 1 drops at count 2, pending requester 3 then wins.
        testName = "abort";
        l = mkLen(6'd7, 6'd10, 6'd7, 6'd2);
        applyStimulus(4'b0010, l, 1'b0, 4'b0010, 4'h0, 1'b1, 6'd0);
        applyStimulus(4'b1010, l, 1'b0, 4'b0010, 4'h0, 1'b1, 6'd1);
        applyStimulus(4'b1010, l, 1'b0, 4'b0010, 4'h0, 1'b1, 6'd2);
        applyStimulus(4'b1000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b1000, l, 1'b0, 4'b1000, 4'h0, 1'b1, 6'd0);
        applyStimulus(4'b1000, l, 1'b0, 4'b1000, 4'h0, 1'b1, 6'd1);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'b1000, 1'b1, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);

        // Reset mid-interval: silent abort, pointer back to requester 0.
        testName = "midrst";
        l = mkLen(6'd20, 6'd4, 6'd4, 6'd4);
        for (int k = 0; k < 6; k++)
            applyStimulus(4'b0001, l, 1'b0, 4'b0001, 4'h0, 1'b1, 6'(k));
        applyStimulus(4'b0011, l, 1'b1, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b0011, l, 1'b1, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b0011, l, 1'b0, 4'b0001, 4'h0, 1'b1, 6'd0);
        applyStimulus(4'b0010, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b0010, l, 1'b0, 4'b0010, 4'h0, 1'b1, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);
        applyStimulus(4'b0000, l, 1'b0, 4'h0, 4'h0, 1'b0, 6'd0);

        repeat (3) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
